// File: rtl/multiword_add_seq.sv
// Multi-word adder sequencer: streams NIBBLES 4-bit slices through an external 4-bit adder, LSB
// first, chaining the carry in a register. Define ADDSEQ_SUB_EN to enable subtract mode via `sub`.
module multiword_add_seq #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  input  logic                   cin,
  input  logic                   sub,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_sum,
  input  logic                   add_cout,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout,
  output logic                   ovf
);

  localparam int unsigned W    = 4 * NIBBLES;
  localparam int unsigned IdxW = $clog2(NIBBLES);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NIBBLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic [W-1:0]      result_q, result_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  logic [W-1:0]      op_b_eff;
  logic              cin_eff;

`ifdef ADDSEQ_SUB_EN
  // Two's-complement subtract: A + ~B + 1, so cout=1 means no borrow.
  assign op_b_eff = sub ? ~op_b : op_b;
  assign cin_eff  = sub ? 1'b1  : cin;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign op_b_eff   = op_b;
  assign cin_eff    = cin;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    add_a    = 4'h0;
    add_b    = 4'h0;
    add_cin  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d      = op_a;
          b_d      = op_b_eff;
          carry_d  = cin_eff;
          idx_d    = '0;
          result_d = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        busy    = 1'b1;
        add_a   = a_q[{idx_q, 2'b00} +: 4];
        add_b   = b_q[{idx_q, 2'b00} +: 4];
        add_cin = carry_q;
        result_d[{idx_q, 2'b00} +: 4] = add_sum;
        carry_d = add_cout;
        if (idx_q == IdxLast) begin
          cout_d  = add_cout;
          // The result MSB is the top bit of the slice being written this cycle.
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_sum[3] != a_q[W-1]);
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed bench for multiword_add_seq (NIBBLES=4) with a behavioural 4-bit adder attached.
module tb_multiword_add_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] op_a, op_b;
  logic        cin, sub;
  logic [3:0]  add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic        busy, done, cout, ovf;
  logic [15:0] result;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

  multiword_add_seq #(.NIBBLES(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
    .cin      (cin),
    .sub      (sub),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .ovf      (ovf)
  );

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        s;
    logic [15:0] exp_r;
    logic        exp_c;
    logic        exp_o;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Issues one operation and checks the adder drive per nibble, latency and final outputs.
  task automatic run_vec(input vec_t v);
    logic [15:0] b_eff;
    logic        c;
    logic [4:0]  s5;
    int          cnt;
    bit          got;
    b_eff = v.s ? ~v.b : v.b;
    c     = v.s ? 1'b1 : v.ci;
    @(negedge clk);
    op_a = v.a; op_b = v.b; cin = v.ci; sub = v.s; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    got = 1'b0;
    cnt = 0;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(negedge clk);
      cnt = i;
      if (done) begin
        got = 1'b1;
      end else if (i <= 4) begin
        chk({v.name, " add_a"},   {28'b0, add_a},   {28'b0, v.a[4*(i-1) +: 4]});
        chk({v.name, " add_b"},   {28'b0, add_b},   {28'b0, b_eff[4*(i-1) +: 4]});
        chk({v.name, " add_cin"}, {31'b0, add_cin}, {31'b0, c});
        chk({v.name, " busy"},    {31'b0, busy},    32'd1);
        s5 = {1'b0, v.a[4*(i-1) +: 4]} + {1'b0, b_eff[4*(i-1) +: 4]} + {4'b0, c};
        c  = s5[4];
      end
    end
    chk({v.name, " done_seen"}, {31'b0, got}, 32'd1);
    chk({v.name, " latency"},   cnt,          32'd5);
    chk({v.name, " result"},    {16'b0, result}, {16'b0, v.exp_r});
    chk({v.name, " cout"},      {31'b0, cout},   {31'b0, v.exp_c});
    chk({v.name, " ovf"},       {31'b0, ovf},    {31'b0, v.exp_o});
    @(negedge clk);
    chk({v.name, " done_1cyc"}, {31'b0, done}, 32'd0);
    chk({v.name, " idle"},      {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    int   dones, saw_idle;
    logic [15:0] r1;
    bit   got;

    vecs[0] = '{"v_5555",  16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{"v_ripple",16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{"v_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{"v_cin",   16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
    vecs[4] = '{"v_negov", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[5] = '{"v_allf",  16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{"v_mid",   16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};

    rst_n = 1'b0; start = 1'b0; op_a = 16'hA5A5; op_b = 16'h5A5A; cin = 1'b1; sub = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst result",  {16'b0, result}, 32'd0);
    chk("rst busy",    {31'b0, busy},   32'd0);
    chk("rst done",    {31'b0, done},   32'd0);
    chk("rst cout",    {31'b0, cout},   32'd0);
    chk("rst ovf",     {31'b0, ovf},    32'd0);
    chk("rst add_a",   {28'b0, add_a},  32'd0);
    chk("rst add_b",   {28'b0, add_b},  32'd0);
    chk("rst add_cin", {31'b0, add_cin}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle no start busy", {31'b0, busy}, 32'd0);
    chk("idle add_a",         {28'b0, add_a}, 32'd0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // start held for 10 edges: one done in the window, re-accept only after IDLE.
    @(negedge clk);
    op_a = 16'h0001; op_b = 16'h0001; cin = 1'b0; sub = 1'b0; start = 1'b1;
    dones = 0; saw_idle = 0; r1 = 16'h0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) op_a = 16'h0F00;
      if (done) begin
        dones++;
        r1 = result;
      end
      if (i == 5 && !busy) saw_idle = 1;
    end
    start = 1'b0;
    chk("hold one_done",   dones,          32'd1);
    chk("hold first_res",  {16'b0, r1},    32'h0002);
    chk("hold idle_gap",   saw_idle,       32'd1);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    chk("hold second_done", {31'b0, got},     32'd1);
    chk("hold second_res",  {16'b0, result},  32'h0F01);
    @(negedge clk);

    // Reset during the 2nd RUN cycle aborts the operation.
    op_a = 16'h1111; op_b = 16'h1111; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort pre result", {16'b0, result}, 32'h0002);
    rst_n = 1'b0;
    #1;
    chk("abort result",  {16'b0, result}, 32'd0);
    chk("abort busy",    {31'b0, busy},   32'd0);
    chk("abort add_a",   {28'b0, add_a},  32'd0);
    chk("abort add_cin", {31'b0, add_cin}, 32'd0);
    chk("abort cout",    {31'b0, cout},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("abort no_done", dones, 32'd0);
    chk("abort held0",   {16'b0, result}, 32'd0);
    run_vec('{"after_rst", 16'h00AB, 16'h0011, 1'b0, 1'b0, 16'h00BC, 1'b0, 1'b0});

`ifdef ADDSEQ_SUB_EN
    run_vec('{"sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0});
    run_vec('{"sub_pos", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end

endmodule
